// File: rtl/sdpb_line_reader.sv
// Port-B line reader for the frame BRAM: issues LENGTH wrapped reads from BASE_ADDR and
// re-times the fixed-latency read data through a credit-checked skid FIFO onto a valid/ready stream.
module sdpb_line_reader #(
    parameter int ADDRESS_DEPTH = 120,
    parameter int DATA_WIDTH    = 128,
    parameter int READ_LATENCY  = 1,
    parameter int FIFO_DEPTH    = READ_LATENCY + 2,
    localparam int AW = $clog2(ADDRESS_DEPTH),
    localparam int LW = $clog2(ADDRESS_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [LW-1:0]         length,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         adb,
    output logic                  ceb,
    output logic                  oce,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    // Stream handshake: a word transfers on m_valid & m_ready; while m_valid=1 and
    // m_ready=0 the head word (m_data, m_last) is held unchanged.
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [LW-1:0]           rem_q, rem_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d, tag_q, tag_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic                    last_mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_q, rd_q;
    logic [CW-1:0]           cnt_q, inflight;
    logic                    issue, issue_last, credit_ok, push, pop;
    logic [AW-1:0]           issue_addr;

    function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
        return (a == AW'(ADDRESS_DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = inc_addr(base_addr);
                        rem_d   = length - LW'(1);
                        state_d = (length == LW'(1)) ? S_DRAIN : S_READ;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d = inc_addr(addr_q);
                    rem_d  = rem_q - LW'(1);
                    if (rem_q == LW'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight == '0 && cnt_q == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The first word is read in the start cycle itself so that data reaches the stream
    // READ_LATENCY+1 cycles after start. Same-cycle pops are deliberately not credited.
    always_comb begin
        issue      = 1'b0;
        issue_addr = addr_q;
        issue_last = (rem_q == LW'(1));
        credit_ok  = (SW'(cnt_q) + SW'(inflight)) < SW'(FIFO_DEPTH);
        case (state_q)
            S_IDLE: begin
                issue_addr = base_addr;
                issue_last = (length == LW'(1));
                issue      = start && (length != '0);
            end
            S_READ:  issue = (rem_q != '0) && credit_ok;
            default: issue = 1'b0;
        endcase
        if (reset) issue = 1'b0;
    end

    assign ceb  = issue;
    assign adb  = issue ? issue_addr : '0;
    assign oce  = 1'b1;
    assign busy = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    always_comb begin
        vld_d    = '0;
        tag_d    = '0;
        vld_d[0] = issue;
        tag_d[0] = issue_last;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(vld_q[i]);
        end
    end

    assign push = vld_q[READ_LATENCY-1];
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            tag_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            if (push) wr_q <= inc_ptr(wr_q);
            if (pop)  rd_q <= inc_ptr(rd_q);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (!push && pop) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage needs no reset: the count gates everything that reads it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q]      <= bram_dout;
            last_mem_q[wr_q] <= tag_q[READ_LATENCY-1];
        end
    end

    assign m_valid = (cnt_q != '0);
    assign m_data  = m_valid ? mem_q[rd_q] : '0;
    assign m_last  = m_valid ? last_mem_q[rd_q] : 1'b0;

endmodule

// File: tb/tb_sdpb_line_reader.sv
// Bench for sdpb_line_reader: latency-1 and latency-2 instances share one stimulus stream and
// are each checked every cycle against a word/address model built from base, length and memory.
`timescale 1ns/1ps
module tb_sdpb_line_reader;
  localparam int D  = 120;
  localparam int DW = 128;
  localparam int AW = 7;
  localparam int LW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start = 1'b0;
  logic          m_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;

  logic          busy [2], done [2], ceb [2], oce [2], m_valid [2], m_last [2];
  logic [AW-1:0] adb [2];
  logic [DW-1:0] dout [2], m_data [2];

  sdpb_line_reader #(.ADDRESS_DEPTH(D), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy[0]), .done(done[0]), .adb(adb[0]), .ceb(ceb[0]), .oce(oce[0]),
    .bram_dout(dout[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready),
    .m_last(m_last[0]));

  sdpb_line_reader #(.ADDRESS_DEPTH(D), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy[1]), .done(done[1]), .adb(adb[1]), .ceb(ceb[1]), .oce(oce[1]),
    .bram_dout(dout[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready),
    .m_last(m_last[1]));

  // BRAM port-B model: bypass read for instance 0, extra output register for instance 1
  logic [DW-1:0] mem [D];
  logic [DW-1:0] p1 [2], p2 [2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ceb[d]) p1[d] <= mem[adb[d]];
      p2[d] <= p1[d];
    end
  end
  assign dout[0] = p1[0];
  assign dout[1] = p2[1];

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] exp_addr_q [$];
  logic [AW-1:0] adb_log [$];
  int   fd [2] = '{3, 4};
  int   lat [2] = '{1, 2};
  int   ceb_idx [2], pop_idx [2], done_cnt [2], done_cyc [2], first_valid [2], last_pop [2];
  logic prev_stall [2], prev_last [2];
  logic [DW-1:0] prev_data [2];
  logic [DW:0]   cmp_e;
  logic chk_en = 1'b0;
  int   start_cyc = 0;

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic chkd(input string name, input int d, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (ceb[d]) begin
          if (ceb_idx[d] < exp_addr_q.size())
            chk("adb", d, int'(adb[d]), int'(exp_addr_q[ceb_idx[d]]));
          else
            chk("extra_ceb", d, ceb_idx[d] + 1, exp_addr_q.size());
          ceb_idx[d]++;
          if (d == 0) adb_log.push_back(adb[d]);
          chk("buffered_within_depth", d, int'(ceb_idx[d] - pop_idx[d] <= fd[d]), 1);
        end
        if (m_valid[d] && first_valid[d] < 0) first_valid[d] = cyc;
        if (prev_stall[d]) begin
          chk("hold_valid", d, int'(m_valid[d]), 1);
          chkd("hold_data", d, m_data[d], prev_data[d]);
          chk("hold_last", d, int'(m_last[d]), int'(prev_last[d]));
        end
        if (m_valid[d] && m_ready) begin
          if (pop_idx[d] < exp_q.size()) begin
            cmp_e = exp_q[pop_idx[d]];
            chkd("m_data", d, m_data[d], cmp_e[DW-1:0]);
            chk("m_last", d, int'(m_last[d]), int'(cmp_e[DW]));
          end else begin
            chk("extra_word", d, pop_idx[d] + 1, exp_q.size());
          end
          pop_idx[d]++;
          if (m_last[d]) last_pop[d] = cyc;
        end
        prev_stall[d] = m_valid[d] && !m_ready;
        prev_data[d]  = m_data[d];
        prev_last[d]  = m_last[d];
        if (done[d]) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_busy"}, d, int'(busy[d]), 0);
      chk({tag, "_done"}, d, int'(done[d]), 0);
      chk({tag, "_ceb"}, d, int'(ceb[d]), 0);
      chk({tag, "_adb"}, d, int'(adb[d]), 0);
      chk({tag, "_valid"}, d, int'(m_valid[d]), 0);
      chk({tag, "_last"}, d, int'(m_last[d]), 0);
      chkd({tag, "_data"}, d, m_data[d], '0);
      chk({tag, "_oce"}, d, int'(oce[d]), 1);
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 10 cycles mid-line, 3: start pulse while busy
  task automatic run_line(input int base, input int len, input int mode);
    int k;
    exp_q.delete();
    exp_addr_q.delete();
    adb_log.delete();
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(AW'((base + i) % D));
      exp_q.push_back({(i == len - 1), mem[(base + i) % D]});
    end
    for (int d = 0; d < 2; d++) begin
      ceb_idx[d] = 0; pop_idx[d] = 0; done_cnt[d] = 0; done_cyc[d] = -1;
      first_valid[d] = -1; last_pop[d] = -1; prev_stall[d] = 1'b0;
    end
    chk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(base);
    length = LW'(len);
    m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom_range(0, D - 1));
    length = LW'($urandom_range(0, D));
    for (k = 1; k <= 1000 && !(done_cnt[0] > 0 && done_cnt[1] > 0); k++) begin
      case (mode)
        1: m_ready = 1'($urandom_range(0, 1));
        2: m_ready = !(k >= 4 && k < 14);
        3: begin
          m_ready = 1'b1;
          start = (k == 3);
        end
        default: m_ready = 1'b1;
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
    m_ready = 1'b1;
    chk("done_within_budget", 0, int'(done_cnt[0] > 0 && done_cnt[1] > 0), 1);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("words_delivered", d, pop_idx[d], len);
      chk("reads_issued", d, ceb_idx[d], len);
      chk("done_pulses", d, done_cnt[d], 1);
      chk("busy_after_line", d, int'(busy[d]), 0);
      if (len > 0 && mode == 0) begin
        chk("first_valid_latency", d, first_valid[d] - start_cyc, lat[d] + 1);
        chk("streaming_rate", d, last_pop[d] - first_valid[d], len - 1);
      end
      if (len == 0) begin
        chk("len0_no_valid", d, first_valid[d], -1);
        chk("len0_done_quick", d, int'(done_cyc[d] - start_cyc <= 2), 1);
      end
    end
    chk_en = 1'b0;
  endtask

  task automatic check_adb_log(input int a0, input int a1, input int a2, input int a3);
    int t [4];
    t = '{a0, a1, a2, a3};
    chk("adb_log_len", 0, adb_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("adb_seq", 0, (i < adb_log.size()) ? int'(adb_log[i]) : -1, t[i]);
  endtask

  initial begin
    for (int i = 0; i < D; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    length = LW'(4);
    #1;
    check_idle_outputs("reset");
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_line(5, 4, 0);
    check_adb_log(5, 6, 7, 8);
    run_line(118, 4, 0);
    check_adb_log(118, 119, 0, 1);
    run_line(40, 0, 0);
    run_line(30, 16, 2);
    run_line(50, 16, 3);
    run_line(60, 120, 1);
    run_line(119, 1, 0);

    for (int n = 0; n < 10; n++)
      run_line($urandom_range(0, D - 1),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, D) : $urandom_range(0, 24),
               $urandom_range(0, 2));

    // abandon a line with an asynchronous reset, then read again
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(10);
    length = LW'(30);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_line(10, 30, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
